// File: rtl/clk_toggle_arbiter_pkg.sv
// rtl/clk_toggle_arbiter_pkg.sv - shared types and width helpers for the toggle arbiter
package clk_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Width of a requester index; never below one bit
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of the hold counter, which only ever holds 0..HOLD_CYCLES-1
  function automatic int hold_w(input int h);
    return (h < 2) ? 1 : $clog2(h);
  endfunction

endpackage

// File: rtl/clk_toggle_arbiter_if.sv
// rtl/clk_toggle_arbiter_if.sv - requester/grant bundle between requesters and the arbiter
interface clk_toggle_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
);
  import clk_arb_pkg::*;

  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;
  logic               dummy_out;
  logic [CNT_W-1:0]   toggle_count;

  // Requester side drives the request lines and observes the grant
  modport master (
    output req,
    input  gnt, gnt_id, busy, dummy_out, toggle_count
  );

  // Arbiter side
  modport slave (
    input  req,
    output gnt, gnt_id, busy, dummy_out, toggle_count
  );

endinterface

// File: rtl/clk_toggle_arbiter_rr_pick.sv
// rtl/clk_toggle_arbiter_rr_pick.sv - first set request at or after a pointer, with wrap
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  // Scan offsets from the far end down so the nearest hit after ptr wins
  always_comb begin
    int p;
    valid = 1'b0;
    idx   = '0;
    p     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      p = (int'(ptr) + k) % NUM_REQ;
      if (req[p]) begin
        valid = 1'b1;
        idx   = ID_W'(p);
      end
    end
  end

endmodule

// File: rtl/clk_toggle_arbiter.sv
// rtl/clk_toggle_arbiter.sv - round-robin arbiter sharing one toggle register
module clk_toggle_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input logic                 clk,
  input logic                 rst,
  clk_toggle_arbiter_if.slave bus
);
  import clk_arb_pkg::*;

  localparam int ID_W   = id_w(NUM_REQ);
  localparam int HOLD_W = hold_w(HOLD_CYCLES);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
  logic [ID_W-1:0]    id_q, id_nxt;
  logic               busy_q, busy_nxt;
  logic               dummy_q, dummy_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State and output registers; reset leaves no toggle pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      id_q     <= '0;
      busy_q   <= 1'b0;
      dummy_q  <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
      gnt_q    <= gnt_nxt;
      id_q     <= id_nxt;
      busy_q   <= busy_nxt;
      dummy_q  <= dummy_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  // Next-state: grant from IDLE, hold or release in GRANT, one dead cycle in GAP
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt_q;
    id_nxt    = id_q;
    busy_nxt  = busy_q;
    dummy_nxt = dummy_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          id_nxt    = pick_idx;
          busy_nxt  = 1'b1;
          dummy_nxt = ~dummy_q;
          cnt_nxt   = cnt_q + 1'b1;
          hold_nxt  = HOLD_W'(HOLD_CYCLES - 1);
          rr_nxt    = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[id_q] || hold_cnt == '0) begin
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = GAP;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.gnt          = gnt_q;
  assign bus.gnt_id       = id_q;
  assign bus.busy         = busy_q;
  assign bus.dummy_out    = dummy_q;
  assign bus.toggle_count = cnt_q;

endmodule
